// File: rtl/watch_display_mux.sv
// watch_display_mux: four-digit common-anode seven-segment scanner.
// Snapshots the BCD digits once per frame, scans d0..d3 with a blank
// window at the start of every slot, blanks leading zeros, shows codes
// 10..15 as a dash and blinks the digit-2 decimal point on seconds ticks.
module watch_display_mux #(
    parameter int DWELL = 50000,
    parameter int BLANK = 500
) (
    input  logic        CLK_IN,
    input  logic        RST,
    input  logic [15:0] BCD_IN,
    input  logic        LZB,
    input  logic        DP_TICK,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN,
    output logic        FRAME
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [15:0]   snap;
    logic          dp_state;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digit;
    logic [3:0]    lz_blank;
    logic          slot_off;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next-output decode from the current scan position and snapshot.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (sel == 2'd3);
        digit     = snap[{sel, 2'b00} +: 4];

        // A digit is a leading zero only if it and every digit above it are zero;
        // the rightmost digit always shows.
        lz_blank[0] = 1'b0;
        lz_blank[1] = LZB && (snap[15:4]  == 12'h000);
        lz_blank[2] = LZB && (snap[15:8]  == 8'h00);
        lz_blank[3] = LZB && (snap[15:12] == 4'h0);

        slot_off = (cnt < CNT_BLANK) || lz_blank[sel];

        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if (!slot_off) begin
            an_nxt  = ~(4'b0001 << sel);
            seg_nxt = decode(digit);
            dp_nxt  = !((sel == 2'd2) && dp_state);
        end
    end

    // Scan counters, frame snapshot, DP toggle and registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            cnt      <= '0;
            sel      <= 2'd0;
            snap     <= 16'h0000;
            dp_state <= 1'b0;
            AN       <= 4'b1111;
            SEG      <= 7'b1111111;
            DP       <= 1'b1;
            FRAME    <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_end) begin
                snap  <= BCD_IN;
                FRAME <= 1'b1;
            end else begin
                FRAME <= 1'b0;
            end

            if (DP_TICK) begin
                dp_state <= ~dp_state;
            end

            AN  <= an_nxt;
            SEG <= seg_nxt;
            DP  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_watch_display_mux.sv
// Directed bench for watch_display_mux with DWELL=8, BLANK=2 (32-cycle frame).
module tb_watch_display_mux;

    logic        CLK_IN = 1'b0;
    logic        RST;
    logic [15:0] BCD_IN;
    logic        LZB;
    logic        DP_TICK;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;
    logic        FRAME;

    int checks = 0;
    int errors = 0;

    logic [3:0] cap_an    [1:32];
    logic [6:0] cap_seg   [1:32];
    logic       cap_dp    [1:32];
    logic       cap_frame [1:32];

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SD = 7'b0111111, OFF = 7'b1111111;

    watch_display_mux #(.DWELL(8), .BLANK(2)) dut (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .BCD_IN (BCD_IN),
        .LZB    (LZB),
        .DP_TICK(DP_TICK),
        .SEG    (SEG),
        .DP     (DP),
        .AN     (AN),
        .FRAME  (FRAME)
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic wait_frame();
        bit found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            step();
            if (FRAME === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_frame: FRAME not seen within 100 cycles");
        end
    endtask

    // Records one full frame starting right after a FRAME sample.
    task automatic capture(input int change_at, input logic [15:0] nv);
        for (int i = 1; i <= 32; i++) begin
            step();
            cap_an[i]    = AN;
            cap_seg[i]   = SEG;
            cap_dp[i]    = DP;
            cap_frame[i] = FRAME;
            if (i == change_at) BCD_IN = nv;
        end
    endtask

    task automatic pulse_tick();
        DP_TICK = 1'b1;
        step();
        DP_TICK = 1'b0;
    endtask

    task automatic test_scan();
        logic [6:0] es [4] = '{S4, S3, S2, S1};
        capture(0, 16'h1234);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            logic       ef;
            if (p < 2) begin ea = 4'hF; eg = OFF; end
            else begin ea = ~(4'b0001 << s); eg = es[s]; end
            ef = (i == 32);
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg || cap_frame[i] !== ef || cap_dp[i] !== 1'b1) begin
                errors++;
                $display("FAIL scan_1234 i=%0d got an=%b seg=%b frame=%b dp=%b expected an=%b seg=%b frame=%b dp=1",
                         i, cap_an[i], cap_seg[i], cap_frame[i], cap_dp[i], ea, eg, ef);
            end
        end
    endtask

    task automatic test_anti_tear();
        logic [6:0] e1 [4] = '{S4, S3, S2, S1};
        logic [6:0] e2 [4] = '{S8, S7, S6, S5};
        capture(12, 16'h5678);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            if (p < 2) begin ea = 4'hF; eg = OFF; end
            else begin ea = ~(4'b0001 << s); eg = e1[s]; end
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg) begin
                errors++;
                $display("FAIL anti_tear_old i=%0d got an=%b seg=%b expected an=%b seg=%b",
                         i, cap_an[i], cap_seg[i], ea, eg);
            end
        end
        capture(0, 16'h5678);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            if (p < 2) begin ea = 4'hF; eg = OFF; end
            else begin ea = ~(4'b0001 << s); eg = e2[s]; end
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg) begin
                errors++;
                $display("FAIL anti_tear_new i=%0d got an=%b seg=%b expected an=%b seg=%b",
                         i, cap_an[i], cap_seg[i], ea, eg);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (AN !== 4'b1101 || SEG !== S7) begin
            errors++;
            $display("FAIL reset_pre got an=%b seg=%b expected an=1101 seg=%b", AN, SEG, S7);
        end
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (AN !== 4'hF || SEG !== OFF || DP !== 1'b1 || FRAME !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got an=%b seg=%b dp=%b frame=%b expected an=1111 seg=1111111 dp=1 frame=0",
                         i, AN, SEG, DP, FRAME);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (AN !== 4'hF || SEG !== OFF || DP !== 1'b1 || FRAME !== 1'b0) begin
                errors++;
                $display("FAIL reset_blank cyc=%0d got an=%b seg=%b dp=%b frame=%b expected an=1111 seg=1111111 dp=1 frame=0",
                         i, AN, SEG, DP, FRAME);
            end
        end
        step();
        checks++;
        if (AN !== 4'b1110 || SEG !== S0) begin
            errors++;
            $display("FAIL reset_first_digit got an=%b seg=%b expected an=1110 seg=%b", AN, SEG, S0);
        end
    endtask

    task automatic test_lzb();
        logic [6:0] ea5 [4] = '{S5, OFF, OFF, OFF};
        logic [6:0] eb  [4] = '{S0, S0, S1, OFF};
        BCD_IN = 16'h0005;
        LZB    = 1'b1;
        wait_frame();
        capture(0, 16'h0005);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            if (p < 2 || s != 0) begin ea = 4'hF; eg = OFF; end
            else begin ea = 4'b1110; eg = ea5[s]; end
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg) begin
                errors++;
                $display("FAIL lzb_0005 i=%0d got an=%b seg=%b expected an=%b seg=%b",
                         i, cap_an[i], cap_seg[i], ea, eg);
            end
        end
        BCD_IN = 16'h0100;
        capture(0, 16'h0100);
        capture(0, 16'h0100);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            if (p < 2 || s == 3) begin ea = 4'hF; eg = OFF; end
            else begin ea = ~(4'b0001 << s); eg = eb[s]; end
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg) begin
                errors++;
                $display("FAIL lzb_0100 i=%0d got an=%b seg=%b expected an=%b seg=%b",
                         i, cap_an[i], cap_seg[i], ea, eg);
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] es [4] = '{S0, SD, S0, S0};
        BCD_IN = 16'h00A0;
        LZB    = 1'b0;
        capture(0, 16'h00A0);
        capture(0, 16'h00A0);
        for (int i = 1; i <= 32; i++) begin
            int s = (i - 1) / 8;
            int p = (i - 1) % 8;
            logic [3:0] ea;
            logic [6:0] eg;
            if (p < 2) begin ea = 4'hF; eg = OFF; end
            else begin ea = ~(4'b0001 << s); eg = es[s]; end
            checks++;
            if (cap_an[i] !== ea || cap_seg[i] !== eg) begin
                errors++;
                $display("FAIL invalid_00A0 i=%0d got an=%b seg=%b expected an=%b seg=%b",
                         i, cap_an[i], cap_seg[i], ea, eg);
            end
        end
    endtask

    task automatic test_dp();
        BCD_IN = 16'h1234;
        LZB    = 1'b0;
        // Phase 0: one tick (DP lit), 1: second tick (DP dark), 2: tick then reset.
        for (int ph = 0; ph < 3; ph++) begin
            pulse_tick();
            if (ph == 2) begin
                RST     = 1'b1;
                DP_TICK = 1'b1;
                step();
                RST     = 1'b0;
                DP_TICK = 1'b0;
            end
            wait_frame();
            capture(0, 16'h1234);
            for (int i = 1; i <= 32; i++) begin
                int s = (i - 1) / 8;
                int p = (i - 1) % 8;
                logic ed;
                ed = !(ph == 0 && s == 2 && p >= 2);
                checks++;
                if (cap_dp[i] !== ed) begin
                    errors++;
                    $display("FAIL dp_phase%0d i=%0d got dp=%b expected dp=%b", ph, i, cap_dp[i], ed);
                end
            end
        end
    endtask

    initial begin
        RST     = 1'b1;
        BCD_IN  = 16'h1234;
        LZB     = 1'b0;
        DP_TICK = 1'b0;
        step();
        step();
        step();
        RST = 1'b0;
        wait_frame();
        test_scan();
        test_anti_tear();
        test_reset();
        test_lzb();
        test_invalid();
        test_dp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
